// File: rtl/riscv_pkg.sv
// riscv_pkg: constants, fetch state encoding and IF/ID bundle
// shared by the fetch stage and the decode/hazard logic.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] instr;
    } ifid_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/riscv_fetch_stage_if.sv
// riscv_fetch_stage_if: instruction-memory request/response bundle.
// master = fetch stage, slave = instruction memory.
interface riscv_fetch_stage_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;

    modport master (
        output imemReq, imemAddr,
        input  imemRdata, imemValid
    );

    modport slave (
        input  imemReq, imemAddr,
        output imemRdata, imemValid
    );
endinterface

// File: rtl/riscv_fetch_stage_ifid_reg.sv
// riscv_ifid_reg: IF/ID pipeline register.
// kill beats stall; an empty slot always carries the NOP word.
module riscv_ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  kill,
    input  logic  load,
    input  ifid_t din,
    output ifid_t q,
    output logic  valid
);

    // Load, hold, kill or bubble the decode slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '{pc: '0, pcPlus4: '0, instr: NOP_WORD};
            valid <= 1'b0;
        end else if (kill) begin
            q.instr <= NOP_WORD;
            valid   <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                q     <= din;
                valid <= 1'b1;
            end else begin
                q.instr <= NOP_WORD;
                valid   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC, single-outstanding fetch FSM, IF/ID register.
// Option RISCV_FETCH_MISALIGN_TRAP_EN: misaligned redirect traps and halts fetch.
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                pcSrc,
    input  logic [31:0]         branchTarget,
    riscv_fetch_stage_if.master imem,
    output logic [31:0]         ifidPc,
    output logic [31:0]         ifidPcPlus4,
    output logic [31:0]         ifidInstr,
    output logic                ifidValid,
    output logic                misalignTrap
);
    import riscv_pkg::*;

    fetch_state_e state, stateN;
    logic [31:0]  pc, pcN, addr, dropAddr;
    logic [31:0]  holdPc, holdInstr, target;
    logic         holdValid, trap, halted, badRedir;
    logic         redir, req, load, capt, kill;
    ifid_t        din, ifidQ;

`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
    assign badRedir = pcSrc && (branchTarget[1:0] != 2'b00);
    assign halted   = trap;

    // Sticky trap: once set, fetch stays halted until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        trap <= 1'b0;
        else if (badRedir) trap <= 1'b1;
    end
`else
    assign badRedir = 1'b0;
    assign halted   = 1'b0;
    assign trap     = 1'b0;
`endif

    assign target       = branchTarget & 32'hFFFF_FFFC;
    assign redir        = pcSrc && !halted && !badRedir;
    assign kill         = flush || pcSrc;
    assign misalignTrap = trap;
    assign imem.imemReq  = req;
    assign imem.imemAddr = addr;

    // Request generation and next-state / next-PC selection.
    always_comb begin
        stateN = state;
        pcN    = pc;
        addr   = pc;
        req    = 1'b0;
        load   = 1'b0;
        capt   = 1'b0;
        din    = '{pc: pc, pcPlus4: pc_inc(pc), instr: imem.imemRdata};
        unique case (state)
            FETCH:   req = !stall && !halted;
            WAIT:    req = 1'b1;
            HOLD:    req = 1'b0;
            DROP: begin
                req  = 1'b1;
                addr = dropAddr;
            end
            default: req = 1'b0;
        endcase
        if (!rst_n) req = 1'b0;
        if (redir) begin
            // An unanswered request must still be drained at its old address.
            pcN    = target;
            stateN = (req && !imem.imemValid) ? DROP : FETCH;
        end else if (badRedir) begin
            stateN = FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (req && imem.imemValid) begin
                        if (!flush) begin
                            load = 1'b1;
                            pcN  = pc_inc(pc);
                        end
                    end else if (req) begin
                        stateN = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imemValid) begin
                        if (stall) begin
                            capt   = 1'b1;
                            pcN    = pc_inc(pc);
                            stateN = HOLD;
                        end else begin
                            stateN = FETCH;
                            if (!flush) begin
                                load = 1'b1;
                                pcN  = pc_inc(pc);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (holdValid && !stall && !flush) begin
                        load   = 1'b1;
                        stateN = FETCH;
                        din    = '{pc: holdPc,
                                   pcPlus4: pc_inc(holdPc),
                                   instr: holdInstr};
                    end
                end
                DROP: begin
                    if (imem.imemValid) stateN = FETCH;
                end
                default: stateN = FETCH;
            endcase
        end
    end

    // PC, FSM state, stale address and stall hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            dropAddr  <= RESET_PC;
            holdPc    <= '0;
            holdInstr <= NOP_INSTR;
            holdValid <= 1'b0;
        end else begin
            state <= stateN;
            pc    <= pcN;
            if (redir) dropAddr <= addr;
            if (capt) begin
                holdPc    <= pc;
                holdInstr <= imem.imemRdata;
            end
            if (pcSrc || load) holdValid <= 1'b0;
            else if (capt)     holdValid <= 1'b1;
        end
    end

    riscv_ifid_reg #(
        .NOP_WORD(NOP_INSTR)
    ) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .kill  (kill),
        .load  (load),
        .din   (din),
        .q     (ifidQ),
        .valid (ifidValid)
    );

    assign ifidPc      = ifidQ.pc;
    assign ifidPcPlus4 = ifidQ.pcPlus4;
    assign ifidInstr   = ifidQ.instr;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: directed scenarios plus randomized run against
// a transaction-level reference model with a variable-latency memory.
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst_n, stall, flush, pcSrc;
    logic [31:0] branchTarget;
    logic [31:0] ifidPc, ifidPcPlus4, ifidInstr;
    logic        ifidValid, misalignTrap;
    int          errors, checks;
    int          minLat, maxLat, busy, curLat;

    riscv_fetch_stage_if imem();

    riscv_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .pcSrc        (pcSrc),
        .branchTarget (branchTarget),
        .imem         (imem),
        .ifidPc       (ifidPc),
        .ifidPcPlus4  (ifidPcPlus4),
        .ifidInstr    (ifidInstr),
        .ifidValid    (ifidValid),
        .misalignTrap (misalignTrap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
    endfunction

    // Memory: answers after curLat cycles of a held request (0 = comb ROM).
    always_comb begin
        imem.imemValid = imem.imemReq && (busy >= curLat);
        imem.imemRdata = memf(imem.imemAddr);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 0;
            curLat <= minLat;
        end else if (imem.imemReq && imem.imemValid) begin
            busy   <= 0;
            curLat <= $urandom_range(maxLat, minLat);
        end else if (imem.imemReq) begin
            busy <= busy + 1;
        end else begin
            busy <= 0;
        end
    end

    // Reference model: next fetch address, one outstanding request
    // (possibly dead), a one-entry stall buffer and the decode slot.
    logic [31:0] m_pc, m_outAddr, m_bufPc, m_bufInstr;
    logic [31:0] e_pc, e_pcp4, e_instr;
    logic        m_out, m_outDead, m_buf, e_valid, m_trap;
    logic [31:0] n_pc, n_outAddr, n_bufPc, n_bufInstr;
    logic [31:0] n_pc_e, n_pcp4, n_instr, m_rd;
    logic        n_out, n_outDead, n_buf, n_valid, n_trap;
    logic        exp_req, m_resp, m_loaded;
    logic [31:0] exp_addr;

    always_comb begin
        exp_req  = 1'b0;
        exp_addr = m_pc;
        if (!rst_n || m_trap) begin
            exp_req = 1'b0;
        end else if (m_out) begin
            exp_req  = 1'b1;
            exp_addr = m_outAddr;
        end else if (!m_buf) begin
            exp_req = !stall;
        end
    end

    always_comb begin
        n_pc = m_pc; n_out = m_out; n_outAddr = m_outAddr;
        n_outDead = m_outDead; n_buf = m_buf; n_bufPc = m_bufPc;
        n_bufInstr = m_bufInstr; n_trap = m_trap;
        n_pc_e = e_pc; n_pcp4 = e_pcp4; n_instr = e_instr; n_valid = e_valid;
        m_resp   = exp_req && imem.imemValid;
        m_rd     = memf(exp_addr);
        m_loaded = 1'b0;
        if (pcSrc && !m_trap) begin
            n_valid = 1'b0;
            n_instr = NOP;
            n_buf   = 1'b0;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
            if (branchTarget[1:0] != 2'b00) begin
                n_trap = 1'b1;
                n_out  = 1'b0;
            end else
`endif
            begin
                n_pc      = {branchTarget[31:2], 2'b00};
                n_out     = exp_req && !imem.imemValid;
                n_outAddr = exp_addr;
                n_outDead = 1'b1;
            end
        end else begin
            if (m_resp) begin
                n_out = 1'b0;
                if (!(m_out && m_outDead)) begin
                    if (stall) begin
                        n_buf      = 1'b1;
                        n_bufPc    = exp_addr;
                        n_bufInstr = m_rd;
                        n_pc       = exp_addr + 32'd4;
                    end else if (!flush) begin
                        m_loaded = 1'b1;
                        n_pc     = exp_addr + 32'd4;
                    end
                end
            end else if (exp_req) begin
                n_out     = 1'b1;
                n_outAddr = exp_addr;
                if (!m_out) n_outDead = 1'b0;
            end
            if (flush) begin
                n_valid = 1'b0;
                n_instr = NOP;
            end else if (!stall) begin
                if (m_loaded) begin
                    n_valid = 1'b1; n_pc_e = exp_addr;
                    n_pcp4 = exp_addr + 32'd4; n_instr = m_rd;
                end else if (m_buf) begin
                    n_valid = 1'b1; n_pc_e = m_bufPc;
                    n_pcp4 = m_bufPc + 32'd4; n_instr = m_bufInstr;
                    n_buf = 1'b0;
                end else begin
                    n_valid = 1'b0;
                    n_instr = NOP;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= '0; m_out <= 1'b0; m_outAddr <= '0; m_outDead <= 1'b0;
            m_buf <= 1'b0; m_bufPc <= '0; m_bufInstr <= '0; m_trap <= 1'b0;
            e_pc <= '0; e_pcp4 <= '0; e_instr <= NOP; e_valid <= 1'b0;
        end else begin
            m_pc <= n_pc; m_out <= n_out; m_outAddr <= n_outAddr;
            m_outDead <= n_outDead; m_buf <= n_buf; m_bufPc <= n_bufPc;
            m_bufInstr <= n_bufInstr; m_trap <= n_trap;
            e_pc <= n_pc_e; e_pcp4 <= n_pcp4; e_instr <= n_instr;
            e_valid <= n_valid;
        end
    end

    task automatic do_reset(input int lo, input int hi);
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pcSrc = 1'b0;
        branchTarget = '0; minLat = lo; maxLat = hi;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (imem.imemReq !== 1'b0) begin errors++;
            $display("FAIL reset_req got=%b want=0", imem.imemReq); end
        checks++; if (ifidValid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got=%b want=0", ifidValid); end
        checks++; if (ifidInstr !== NOP) begin errors++;
            $display("FAIL reset_instr got=%h want=%h", ifidInstr, NOP); end
        checks++; if ({ifidPc, ifidPcPlus4} !== 64'd0) begin errors++;
            $display("FAIL reset_pc got=%h/%h want=0/0", ifidPc, ifidPcPlus4); end
        checks++; if (misalignTrap !== 1'b0) begin errors++;
            $display("FAIL reset_trap got=%b want=0", misalignTrap); end
    endtask

    task automatic test_rom_stream();
        do_reset(0, 0);
        checks++; if ({imem.imemReq, imem.imemAddr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL rom_c0 got=%b/%h want=1/0",
                               imem.imemReq, imem.imemAddr); end
        @(negedge clk); #1;
        checks++; if ({ifidValid, ifidPc, ifidInstr} !== {1'b1, 32'h0, memf(0)}) begin
            errors++; $display("FAIL rom_c1_ifid got=%b/%h/%h want=1/0/%h",
                               ifidValid, ifidPc, ifidInstr, memf(0)); end
        checks++; if (imem.imemAddr !== 32'h4) begin errors++;
            $display("FAIL rom_c1_addr got=%h want=4", imem.imemAddr); end
        @(negedge clk); #1;
        checks++; if ({ifidPc, ifidPcPlus4} !== {32'h4, 32'h8}) begin errors++;
            $display("FAIL rom_c2_ifid got=%h/%h want=4/8", ifidPc, ifidPcPlus4); end
        checks++; if (imem.imemAddr !== 32'h8) begin errors++;
            $display("FAIL rom_c2_addr got=%h want=8", imem.imemAddr); end
    endtask

    task automatic test_stall_hold();
        do_reset(1, 1);
        @(negedge clk); stall = 1'b1; #1;
        checks++; if ({imem.imemReq, imem.imemValid} !== 2'b11) begin errors++;
            $display("FAIL hold_resp got=%b%b want=11", imem.imemReq, imem.imemValid); end
        @(negedge clk); #1;
        checks++; if ({imem.imemReq, ifidValid} !== 2'b00) begin errors++;
            $display("FAIL hold_idle got=%b%b want=00", imem.imemReq, ifidValid); end
        @(negedge clk); stall = 1'b0; #1;
        checks++; if (imem.imemReq !== 1'b0) begin errors++;
            $display("FAIL hold_release_req got=%b want=0", imem.imemReq); end
        @(negedge clk); #1;
        checks++; if ({ifidValid, ifidPc, ifidInstr} !== {1'b1, 32'h0, memf(0)}) begin
            errors++; $display("FAIL hold_ifid got=%b/%h/%h want=1/0/%h",
                               ifidValid, ifidPc, ifidInstr, memf(0)); end
        checks++; if ({imem.imemReq, imem.imemAddr} !== {1'b1, 32'h4}) begin
            errors++; $display("FAIL hold_norefetch got=%b/%h want=1/4",
                               imem.imemReq, imem.imemAddr); end
    endtask

    task automatic test_redirect_drop();
        bit seen;
        do_reset(2, 2);
        @(negedge clk); pcSrc = 1'b1; branchTarget = 32'h100; #1;
        @(negedge clk); pcSrc = 1'b0; #1;
        checks++; if ({imem.imemReq, imem.imemAddr, imem.imemValid} !== {1'b1, 32'h0, 1'b1})
        begin errors++; $display("FAIL drop_stale got=%b/%h/%b want=1/0/1",
                                 imem.imemReq, imem.imemAddr, imem.imemValid); end
        checks++; if (ifidValid !== 1'b0) begin errors++;
            $display("FAIL drop_valid got=%b want=0", ifidValid); end
        @(negedge clk); #1;
        checks++; if ({imem.imemAddr, ifidValid} !== {32'h100, 1'b0}) begin errors++;
            $display("FAIL drop_newaddr got=%h/%b want=100/0", imem.imemAddr, ifidValid); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            seen = ifidValid;
        end
        checks++; if (!seen || ifidPc !== 32'h100 || ifidInstr !== memf(32'h100)) begin
            errors++; $display("FAIL drop_target got=%b/%h/%h want=1/100/%h",
                               seen, ifidPc, ifidInstr, memf(32'h100)); end
    endtask

    task automatic test_redirect_stall();
        do_reset(0, 0);
        repeat (2) @(negedge clk);
        stall = 1'b1; pcSrc = 1'b1; branchTarget = 32'h200; #1;
        checks++; if (imem.imemReq !== 1'b0) begin errors++;
            $display("FAIL rstall_req got=%b want=0", imem.imemReq); end
        @(negedge clk); stall = 1'b0; pcSrc = 1'b0; #1;
        checks++; if ({ifidValid, ifidInstr} !== {1'b0, NOP}) begin errors++;
            $display("FAIL rstall_kill got=%b/%h want=0/%h", ifidValid, ifidInstr, NOP); end
        checks++; if ({imem.imemReq, imem.imemAddr} !== {1'b1, 32'h200}) begin
            errors++; $display("FAIL rstall_addr got=%b/%h want=1/200",
                               imem.imemReq, imem.imemAddr); end
        @(negedge clk); #1;
        checks++; if ({ifidValid, ifidPc} !== {1'b1, 32'h200}) begin errors++;
            $display("FAIL rstall_ifid got=%b/%h want=1/200", ifidValid, ifidPc); end
    endtask

    task automatic test_flush_stall();
        do_reset(0, 0);
        repeat (2) @(negedge clk);
        stall = 1'b1; flush = 1'b1; #1;
        @(negedge clk); flush = 1'b0; #1;
        checks++; if ({ifidValid, ifidInstr} !== {1'b0, NOP}) begin errors++;
            $display("FAIL flush_stall got=%b/%h want=0/%h", ifidValid, ifidInstr, NOP); end
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset(0, 0);
        pcSrc = 1'b1; branchTarget = 32'hFFFF_FFFC;
        @(negedge clk); pcSrc = 1'b0; #1;
        checks++; if (imem.imemAddr !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_addr0 got=%h want=fffffffc", imem.imemAddr); end
        @(negedge clk); #1;
        checks++; if (imem.imemAddr !== 32'h0) begin errors++;
            $display("FAIL wrap_addr1 got=%h want=0", imem.imemAddr); end
        checks++; if ({ifidValid, ifidPc, ifidPcPlus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0})
        begin errors++; $display("FAIL wrap_ifid got=%b/%h/%h want=1/fffffffc/0",
                                 ifidValid, ifidPc, ifidPcPlus4); end
    endtask

    task automatic test_misalign();
        do_reset(0, 0);
        pcSrc = 1'b1; branchTarget = 32'h102;
        @(negedge clk); pcSrc = 1'b0; #1;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if ({misalignTrap, imem.imemReq, ifidValid} !== 3'b100) begin
                errors++; $display("FAIL mis_halt got=%b%b%b want=100",
                                   misalignTrap, imem.imemReq, ifidValid); end
            @(negedge clk); #1;
        end
`else
        checks++; if ({misalignTrap, imem.imemReq, imem.imemAddr} !== {2'b01, 32'h100})
        begin errors++; $display("FAIL mis_fwd got=%b/%b/%h want=0/1/100",
                                 misalignTrap, imem.imemReq, imem.imemAddr); end
        @(negedge clk); #1;
        checks++; if ({ifidValid, ifidPc} !== {1'b1, 32'h100}) begin errors++;
            $display("FAIL mis_ifid got=%b/%h want=1/100", ifidValid, ifidPc); end
`endif
    endtask

    task automatic test_random(input int n);
        do_reset(0, 2);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stall = ($urandom_range(99) < 25);
            pcSrc = ($urandom_range(99) < 8);
            if ($urandom_range(3) == 0)
                branchTarget = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            else
                branchTarget = $urandom & 32'h0000_FFFC;
            flush = pcSrc ? 1'($urandom_range(1)) : ($urandom_range(99) < 4);
            #1;
            checks++; if (imem.imemReq !== exp_req) begin errors++;
                $display("FAIL rnd_req cyc=%0d got=%b want=%b", i, imem.imemReq, exp_req); end
            if (exp_req) begin
                checks++; if (imem.imemAddr !== exp_addr) begin errors++;
                    $display("FAIL rnd_addr cyc=%0d got=%h want=%h",
                             i, imem.imemAddr, exp_addr); end
            end
            checks++; if ({ifidValid, misalignTrap} !== {e_valid, m_trap}) begin errors++;
                $display("FAIL rnd_valid cyc=%0d got=%b%b want=%b%b",
                         i, ifidValid, misalignTrap, e_valid, m_trap); end
            if (e_valid) begin
                checks++; if ({ifidPc, ifidPcPlus4, ifidInstr} !== {e_pc, e_pcp4, e_instr})
                begin errors++; $display("FAIL rnd_ifid cyc=%0d got=%h/%h/%h want=%h/%h/%h",
                    i, ifidPc, ifidPcPlus4, ifidInstr, e_pc, e_pcp4, e_instr); end
            end else begin
                checks++; if (ifidInstr !== NOP) begin errors++;
                    $display("FAIL rnd_nop cyc=%0d got=%h want=%h", i, ifidInstr, NOP); end
            end
        end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; pcSrc = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        pcSrc = 1'b0; branchTarget = '0; minLat = 0; maxLat = 0;
        errors = 0; checks = 0;
        test_reset();
        test_rom_stream();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_stall();
        test_flush_stall();
        test_wrap();
        test_misalign();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
